// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the data-SRAM port arbiter.
// Requester indices, FSM encoding and a one-hot helper.
package sram_port_arbiter_pkg;

    localparam int NREQ      = 3;
    localparam int REQ_HOST  = 0;
    localparam int REQ_FETCH = 1;
    localparam int REQ_WB    = 2;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot3(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_prio_pick3.sv
// Combinational 3-way fixed-priority picker.
// Write-back beats fetch beats host.
module prio_pick3
    import sram_port_arbiter_pkg::*;
(
    input  logic [2:0] mask,
    output logic       any,
    output logic [1:0] idx
);

    // Highest set index wins
    always_comb begin
        any = |mask;
        idx = 2'(REQ_HOST);
        priority case (1'b1)
            mask[REQ_WB]:    idx = 2'(REQ_WB);
            mask[REQ_FETCH]: idx = 2'(REQ_FETCH);
            default:         idx = 2'(REQ_HOST);
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Burst-locked arbiter for the shared single-port data SRAM.
// Fixed priority with starvation promotion; one bubble between owners.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int DATAWIDTH    = 16,
    parameter int ADDRW        = 10,
    parameter int MAX_BURST    = 16,
    parameter int STARVE_LIMIT = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0]             we,
    input  logic [NREQ*ADDRW-1:0]       addr,
    input  logic [NREQ*DATAWIDTH-1:0]   wdata,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             rvalid,
    output logic [DATAWIDTH-1:0]        rdata,
    output logic                        busy,
    output logic [ADDRW-1:0]            sram_addr,
    output logic [DATAWIDTH-1:0]        sram_wdata,
    output logic                        sram_wr,
    input  logic [DATAWIDTH-1:0]        sram_rdata
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int WW = $clog2(STARVE_LIMIT) + 1;

    arb_state_t           state;
    logic [1:0]           own;
    logic [BW-1:0]        bcnt;
    logic [WW-1:0]        wcnt [NREQ];
    logic [ADDRW-1:0]     a_arr [NREQ];
    logic [DATAWIDTH-1:0] d_arr [NREQ];
    logic [NREQ-1:0]      starved;
    logic                 access;
    logic                 last;
    logic                 s_any;
    logic                 r_any;
    logic [1:0]           s_idx;
    logic [1:0]           r_idx;
    logic [1:0]           win;

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign a_arr[g]   = addr[g*ADDRW +: ADDRW];
        assign d_arr[g]   = wdata[g*DATAWIDTH +: DATAWIDTH];
        assign starved[g] = req[g] && (wcnt[g] >= WW'(STARVE_LIMIT));
    end

    prio_pick3 u_pick_starved (
        .mask (starved),
        .any  (s_any),
        .idx  (s_idx)
    );

    prio_pick3 u_pick_req (
        .mask (req),
        .any  (r_any),
        .idx  (r_idx)
    );

    assign win    = s_any ? s_idx : r_idx;
    assign access = (state == OWN) && req[own];
    assign last   = access && (bcnt == BW'(MAX_BURST - 1));
    assign rdata  = sram_rdata;

    // Owner's request drives the SRAM only on an access cycle
    always_comb begin
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wr    = 1'b0;
        if (access) begin
            sram_addr  = a_arr[own];
            sram_wdata = d_arr[own];
            sram_wr    = we[own];
        end
    end

    // Grant FSM: arbitrate in IDLE, hold the grant through the burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            own   <= '0;
            bcnt  <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (r_any) begin
                        state <= OWN;
                        own   <= win;
                        bcnt  <= '0;
                        gnt   <= onehot3(win);
                        busy  <= 1'b1;
                    end
                end
                OWN: begin
                    if (!access || last) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read strobe follows the read access by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
        end else if (access && !we[own]) begin
            rvalid <= onehot3(own);
        end else begin
            rvalid <= '0;
        end
    end

    // Saturating wait counters drive starvation promotion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) wcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    wcnt[i] <= '0;
                end else if (state == IDLE && win == 2'(i)) begin
                    wcnt[i] <= '0;
                end else if (!(state == OWN && own == 2'(i)) &&
                             wcnt[i] < WW'(STARVE_LIMIT)) begin
                    wcnt[i] <= wcnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter.
// A transaction-level model predicts each cycle; a monitor compares.
module tb_sram_port_arbiter;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int MB = 4;
    localparam int SL = 8;

    typedef struct {
        logic [2:0]    gnt;
        logic [2:0]    rvalid;
        logic          busy;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      req = '0;
    logic [2:0]      we = '0;
    logic [3*AW-1:0] addr = '0;
    logic [3*DW-1:0] wdata = '0;
    logic [2:0]      gnt;
    logic [2:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wdata;
    logic            sram_wr;
    logic [DW-1:0]   sram_rdata = '0;

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] ref_mem [1024];

    int checks = 0;
    int errors = 0;
    bit started = 0;
    exp_t q[$];

    int rem [3];
    int idx [3];
    int base [3];
    logic a_we [3];
    logic [DW-1:0] d0 [3];
    bit rand_mode = 0;

    int m_own = -1;
    int m_burst = 0;
    int m_wait [3];
    int m_rv_who = -1;
    logic [DW-1:0] m_rv_data = '0;
    int last_acc = -1;

    sram_port_arbiter #(
        .DATAWIDTH(DW), .ADDRW(AW),
        .MAX_BURST(MB), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_wr(sram_wr), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model with one-cycle read latency
    always @(posedge clk) begin
        if (sram_wr) mem[sram_addr] <= sram_wdata;
        sram_rdata <= mem[sram_addr];
    end

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     n, a, e, $time);
        end
    endtask

    // Monitor: pop one prediction per cycle and compare
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = q.pop_front();
                chk("gnt", 32'(gnt), 32'(e.gnt));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("sram_wr", 32'(sram_wr), 32'(e.wr));
                chk("sram_addr", 32'(sram_addr), 32'(e.addr));
                chk("sram_wdata", 32'(sram_wdata), 32'(e.wdata));
                chk("rvalid", 32'(rvalid), 32'(e.rvalid));
                if (e.rvalid != 0)
                    chk("rdata", 32'(rdata), 32'(e.rdata));
            end
        end
    end

    task automatic start_burst(input int i, input int n, input logic w,
                               input int b, input logic [DW-1:0] d);
        rem[i]  = n;
        idx[i]  = 0;
        base[i] = b;
        a_we[i] = w;
        d0[i]   = d;
    endtask

    task automatic drive();
        for (int i = 0; i < 3; i++) begin
            req[i] = rem[i] > 0;
            we[i]  = a_we[i];
            addr[i*AW +: AW]  = AW'(base[i] + idx[i]);
            wdata[i*DW +: DW] = d0[i] + DW'(idx[i]);
        end
    endtask

    // Reference: owner, access count and per-requester waits
    task automatic model_step();
        exp_t e;
        int acc;
        int win;
        logic [AW-1:0] a;
        if (!rst_n) begin
            m_own = -1;
            m_burst = 0;
            m_wait = '{0, 0, 0};
            m_rv_who = -1;
        end
        acc = (m_own >= 0 && req[m_own]) ? m_own : -1;
        e.gnt    = (m_own >= 0) ? (3'b001 << m_own) : 3'b000;
        e.busy   = m_own >= 0;
        e.wr     = (acc >= 0) && we[acc];
        e.addr   = (acc >= 0) ? addr[acc*AW +: AW] : '0;
        e.wdata  = (acc >= 0) ? wdata[acc*DW +: DW] : '0;
        e.rvalid = (m_rv_who >= 0) ? (3'b001 << m_rv_who) : 3'b000;
        e.rdata  = m_rv_data;
        q.push_back(e);
        last_acc = acc;
        if (!rst_n) begin
            last_acc = -1;
            return;
        end
        m_rv_who = -1;
        if (acc >= 0) begin
            a = addr[acc*AW +: AW];
            if (we[acc]) begin
                ref_mem[a] = wdata[acc*DW +: DW];
            end else begin
                m_rv_who = acc;
                m_rv_data = ref_mem[a];
            end
        end
        win = -1;
        if (m_own < 0) begin
            for (int i = 0; i < 3; i++)
                if (req[i] && m_wait[i] >= SL) win = i;
            if (win < 0)
                for (int i = 0; i < 3; i++)
                    if (req[i]) win = i;
        end
        for (int i = 0; i < 3; i++) begin
            if (!req[i]) m_wait[i] = 0;
            else if (m_own != i && m_wait[i] < SL) m_wait[i]++;
        end
        if (m_own >= 0) begin
            if (acc < 0) begin
                m_own = -1;
            end else begin
                m_burst++;
                if (m_burst == MB) m_own = -1;
            end
        end else if (win >= 0) begin
            m_own = win;
            m_burst = 0;
            m_wait[win] = 0;
        end
    endtask

    task automatic cycle(input logic rst_v);
        @(posedge clk);
        #1;
        rst_n = rst_v;
        if (!rst_v) begin
            rem = '{0, 0, 0};
            last_acc = -1;
        end
        if (last_acc >= 0) begin
            idx[last_acc]++;
            rem[last_acc]--;
        end
        if (rand_mode) begin
            for (int i = 0; i < 3; i++) begin
                if (rem[i] == 0 && $urandom_range(5) == 0)
                    start_burst(i, $urandom_range(6, 1),
                                1'($urandom_range(1)),
                                $urandom_range(1023),
                                DW'($urandom));
                else if (rem[i] > 0 && m_own == i &&
                         $urandom_range(23) == 0)
                    rem[i] = 0;
            end
        end
        drive();
        model_step();
        started = 1;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1'b1);
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int k = 0; k < 400; k++) begin
            if (m_own < 0 && last_acc < 0 &&
                rem[0] == 0 && rem[1] == 0 && rem[2] == 0) begin
                done = 1;
                break;
            end
            cycle(1'b1);
        end
        if (!done) begin
            errors++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
        run(2);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        rem = '{0, 0, 0};
        idx = '{0, 0, 0};
        base = '{0, 0, 0};
        a_we = '{0, 0, 0};
        d0 = '{0, 0, 0};
        m_wait = '{0, 0, 0};

        repeat (3) cycle(1'b0);
        run(2);

        start_burst(0, 4, 1'b1, 0, 16'h00A0);
        wait_idle();

        start_burst(1, 3, 1'b0, 'h10, 16'h0);
        wait_idle();

        start_burst(0, 2, 1'b0, 0, 16'h0);
        start_burst(1, 2, 1'b1, 'h40, 16'h1100);
        start_burst(2, 2, 1'b1, 'h50, 16'h2200);
        wait_idle();

        start_burst(2, 10, 1'b0, 'h40, 16'h0);
        wait_idle();

        start_burst(0, 2, 1'b0, 'h50, 16'h0);
        start_burst(1, 40, 1'b1, 'h100, 16'h3300);
        start_burst(2, 40, 1'b0, 'h200, 16'h0);
        wait_idle();

        start_burst(1, 8, 1'b0, 'h20, 16'h0);
        run(4);
        cycle(1'b0);
        cycle(1'b0);
        run(2);
        start_burst(0, 2, 1'b0, 'h100, 16'h0);
        wait_idle();

        rand_mode = 1;
        run(2000);
        rand_mode = 0;
        rem = '{0, 0, 0};
        wait_idle();

        @(negedge clk);
        #1;
        started = 0;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
